// File: rtl/axi_read_return_pkg.sv
// rtl/axi_read_return_pkg.sv - widths and response codes for the read-return path
`include "axi_bus_defines.svh"

package axi_read_return_pkg;

    localparam int ID_BITS   = `AXI_ID_BITS;
    localparam int RESP_BITS = `AXI_RESP_BITS;

    localparam logic [RESP_BITS-1:0] RESP_OKAY   = `RESP_OKAY;
    localparam logic [RESP_BITS-1:0] RESP_SLVERR = `RESP_SLVERR;

    function automatic logic [RESP_BITS-1:0] resp_of(input logic err);
        return err ? RESP_SLVERR : RESP_OKAY;
    endfunction

endpackage

// File: rtl/axi_bus_defines.svh
// rtl/axi_bus_defines.svh - shared AXI bus field widths and response codes
`ifndef AXI_BUS_DEFINES_SVH
`define AXI_BUS_DEFINES_SVH

`define AXI_ID_BITS   4
`define AXI_RESP_BITS 2
`define RESP_OKAY     2'b00
`define RESP_SLVERR   2'b10

`endif

// File: rtl/rr_sync_fifo.sv
// rtl/rr_sync_fifo.sv - synchronous FIFO with combinational head and full/empty flags
module rr_sync_fifo #(
    parameter int width = 8,
    parameter int depth = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic [width-1:0] push_data,
    input  logic             pop,
    output logic [width-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(depth);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] full_level = CW'(depth);

    logic [width-1:0] mem [depth];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == full_level);
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    // A pop frees the slot in the same cycle, so push-while-full is legal alongside it.
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/axi_read_return.sv
// rtl/axi_read_return.sv - pairs per-beat tags with in-order peripheral data onto the AXI R channel
// Optional AXI_RRESP_ERR_EN adds P_ERR, stored per beat and returned as SLVERR on R_RESP.
module axi_read_return
    import axi_read_return_pkg::*;
#(
    parameter int masters = 4,
    parameter int dwidth  = 128,
    parameter int depth   = 4
) (
    input  logic                 CLK,
    input  logic                 RESETN,
    input  logic [masters-1:0]   T_MASTER,
    input  logic [ID_BITS-1:0]   T_ID,
    input  logic                 T_LAST,
    input  logic                 T_VALID,
    output logic                 T_READY,
    input  logic [dwidth-1:0]    P_DATA,
    input  logic                 P_VALID,
`ifdef AXI_RRESP_ERR_EN
    input  logic                 P_ERR,
`endif
    output logic [masters-1:0]   R_MASTER,
    output logic [ID_BITS-1:0]   R_ID,
    output logic [dwidth-1:0]    R_DATA,
    output logic [RESP_BITS-1:0] R_RESP,
    output logic                 R_LAST,
    output logic                 R_VALID,
    input  logic                 R_READY,
    output logic                 PROTO_ERR
);
    localparam int CW = $clog2(depth) + 1;
    localparam int TW = masters + ID_BITS + 1;
`ifdef AXI_RRESP_ERR_EN
    localparam int DW = dwidth + 1;
`else
    localparam int DW = dwidth;
`endif
    localparam logic [CW-1:0] full_level = CW'(depth);

    logic [CW-1:0] credit;
    logic [CW-1:0] pending;
    logic          tag_hs;
    logic          r_hs;
    logic          data_push;
    logic          tag_full;
    logic          tag_empty;
    logic          data_full;
    logic          data_empty;
    logic [TW-1:0] tag_head;
    logic [DW-1:0] data_in;
    logic [DW-1:0] data_head;

    // Credits cover beats in flight plus buffered, so the unthrottled data side never overflows.
    assign T_READY   = RESETN & (credit < full_level) & ~tag_full;
    assign tag_hs    = T_VALID & T_READY;
    assign R_VALID   = ~data_empty & ~tag_empty;
    assign r_hs      = R_VALID & R_READY;
    assign data_push = P_VALID & (pending != '0) & ~data_full;

`ifdef AXI_RRESP_ERR_EN
    assign data_in = {P_ERR, P_DATA};
    assign R_DATA  = data_head[dwidth-1:0];
    assign R_RESP  = resp_of(data_head[dwidth]);
`else
    assign data_in = P_DATA;
    assign R_DATA  = data_head;
    assign R_RESP  = RESP_OKAY;
`endif

    assign {R_MASTER, R_ID, R_LAST} = tag_head;

    rr_sync_fifo #(.width(TW), .depth(depth)) u_tag_fifo (
        .clk       (CLK),
        .resetn    (RESETN),
        .push      (tag_hs),
        .push_data ({T_MASTER, T_ID, T_LAST}),
        .pop       (r_hs),
        .head      (tag_head),
        .full      (tag_full),
        .empty     (tag_empty)
    );

    rr_sync_fifo #(.width(DW), .depth(depth)) u_data_fifo (
        .clk       (CLK),
        .resetn    (RESETN),
        .push      (data_push),
        .push_data (data_in),
        .pop       (r_hs),
        .head      (data_head),
        .full      (data_full),
        .empty     (data_empty)
    );

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            credit    <= '0;
            pending   <= '0;
            PROTO_ERR <= 1'b0;
        end else begin
            case ({tag_hs, r_hs})
                2'b10:   credit <= credit + CW'(1);
                2'b01:   credit <= credit - CW'(1);
                default: ;
            endcase
            case ({tag_hs, data_push})
                2'b10:   pending <= pending + CW'(1);
                2'b01:   pending <= pending - CW'(1);
                default: ;
            endcase
            // A beat with no outstanding tag cannot be routed; drop it and flag the violation.
            if (P_VALID && pending == '0) begin
                PROTO_ERR <= 1'b1;
            end
        end
    end

endmodule
